// File: rtl/vram_pkg.sv
// vram_pkg: definitions shared by the VRAM read controller and its sub-modules.
//   - FSM state encoding (plain localparams so older tools can consume it)
//   - AXI burst-type and response constants
//   - geometry helpers: bytes per burst and bursts per frame
package vram_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Bytes moved by one read burst of burst_len beats, each data_w bits wide.
  function automatic int burst_bytes(input int burst_len, input int data_w);
    return burst_len * data_w / 8;
  endfunction

  // Number of bursts needed to fetch one whole frame.
  function automatic int burst_count(input int h_pix, input int v_pix, input int pix_bytes,
                                     input int burst_len, input int data_w);
    return (h_pix * v_pix * pix_bytes) / burst_bytes(burst_len, data_w);
  endfunction

endpackage

// File: rtl/vram_rd_ctrl_if.sv
// vram_rd_ctrl_if: AXI read-address and read-data channel bundle.
//   AR: ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID (master out), ARREADY (master in)
//   R : RVALID, RLAST, RRESP (master in), RREADY (master out)
// The read data bus itself goes straight to the pixel FIFO and is not carried here.
interface vram_rd_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic              RVALID;
  logic              RLAST;
  logic [1:0]        RRESP;
  logic              RREADY;

  modport master (
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RVALID, RLAST, RRESP
  );

  modport slave (
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RVALID, RLAST, RRESP
  );
endinterface

// File: rtl/vram_rd_ctrl_sync_edge.sv
// sync_edge: three-flop synchroniser for an asynchronous level, followed by a
// rising-edge detector on the two oldest flops.
//   clk      : destination clock
//   rst_n    : asynchronous active-low reset, clears the whole chain
//   async_in : level from another clock domain
//   pulse    : one-cycle pulse when a 0->1 transition has been synchronised
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [2:0] sync_q;

  // Shift the input through the chain; bit 0 may go metastable, bits 1/2 are safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], async_in};
    end
  end

  assign pulse = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/vram_rd_ctrl.sv
// vram_rd_ctrl: fetches one display frame from VRAM as a sequence of fixed-length
// AXI INCR read bursts, throttled by the pixel FIFO and an outstanding-burst limit.
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   axi           : AXI AR/R master port
//   AXISTART      : asynchronous frame-start request (rising edge starts a frame)
//   DISPON        : display enable; dropping it mid-frame aborts the fetch
//   DISPADDR      : burst-aligned frame base address, captured at frame start
//   FIFOREADY     : pixel FIFO can take one more burst
//   BUSY          : controller is not idle
//   FRAMEDONE     : one-cycle pulse when a complete frame has been fetched
//   RERR          : sticky, set by any error response, cleared at frame start
module vram_rd_ctrl
  import vram_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 16,
  parameter int H_PIX     = 640,
  parameter int V_PIX     = 480,
  parameter int PIX_BYTES = 4,
  parameter int MAX_OUTST = 2
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  vram_rd_ctrl_if.master    axi,
  input  logic              AXISTART,
  input  logic              DISPON,
  input  logic [ADDR_W-1:0] DISPADDR,
  input  logic              FIFOREADY,
  output logic              BUSY,
  output logic              FRAMEDONE,
  output logic              RERR
);

  localparam int BURST_BYTES = burst_bytes(BURST_LEN, DATA_W);
  localparam int NUM_BURSTS  = burst_count(H_PIX, V_PIX, PIX_BYTES, BURST_LEN, DATA_W);
  localparam int CNT_W       = $clog2(NUM_BURSTS) + 1;
  localparam int OUT_W       = $clog2(MAX_OUTST + 1);
  localparam int SIZE        = $clog2(DATA_W / 8);

  logic [1:0]        state;
  logic              arvalid;
  logic [ADDR_W-1:0] araddr;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  burst_idx;
  logic [OUT_W-1:0]  outst;
  logic              framedone;
  logic              rerr;

  logic start_edge;
  logic ar_hs;
  logic r_last_hs;
  logic beat_err;
  logic can_issue;
  logic last_issue;

  sync_edge u_sync (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .async_in (AXISTART),
    .pulse    (start_edge)
  );

  assign ar_hs      = arvalid & axi.ARREADY;
  assign r_last_hs  = axi.RVALID & axi.RREADY & axi.RLAST;
  assign beat_err   = axi.RVALID & axi.RREADY & (axi.RRESP != RESP_OKAY);
  assign last_issue = ar_hs & (burst_idx == CNT_W'(NUM_BURSTS - 1));

  // A new request is only raised from an idle AR channel, so a pending request
  // is never retracted or modified by FIFOREADY/DISPON changes.
  assign can_issue = !arvalid && DISPON && FIFOREADY &&
                     (burst_idx < CNT_W'(NUM_BURSTS)) &&
                     (outst < OUT_W'(MAX_OUTST));

  // Frame sequencing, AR request generation and burst bookkeeping.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= ST_IDLE;
      arvalid   <= 1'b0;
      araddr    <= '0;
      base_q    <= '0;
      burst_idx <= '0;
      outst     <= '0;
      framedone <= 1'b0;
      rerr      <= 1'b0;
    end else begin
      framedone <= 1'b0;

      // A burst issued and another completed in the same cycle cancel out.
      if (ar_hs && !r_last_hs) begin
        outst <= outst + OUT_W'(1);
      end else if (!ar_hs && r_last_hs) begin
        outst <= outst - OUT_W'(1);
      end

      if (ar_hs) begin
        arvalid   <= 1'b0;
        burst_idx <= burst_idx + CNT_W'(1);
      end

      if (beat_err) begin
        rerr <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (start_edge && DISPON) begin
            state     <= ST_RUN;
            base_q    <= DISPADDR;
            burst_idx <= '0;
            rerr      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (can_issue) begin
            arvalid <= 1'b1;
            araddr  <= base_q + ADDR_W'(burst_idx) * ADDR_W'(BURST_BYTES);
          end
          if (!DISPON || last_issue) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Wait for any still-pending request and all returning data.
          if (outst == '0 && !arvalid) begin
            state     <= ST_IDLE;
            framedone <= (burst_idx == CNT_W'(NUM_BURSTS));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign axi.ARADDR  = araddr;
  assign axi.ARVALID = arvalid;
  assign axi.ARLEN   = 8'(BURST_LEN - 1);
  assign axi.ARSIZE  = 3'(SIZE);
  assign axi.ARBURST = BURST_INCR;
  assign axi.RREADY  = 1'b1;

  assign BUSY      = (state != ST_IDLE);
  assign FRAMEDONE = framedone;
  assign RERR      = rerr;

endmodule

// File: tb/tb_vram_rd_ctrl.sv
// tb_vram_rd_ctrl: two controller instances (MAX_OUTST=1 and MAX_OUTST=2) share
// the frame-control inputs; each has its own randomised AXI slave and a
// reference model derived from frame geometry (expected burst addresses,
// outstanding limit, completed bursts before FRAMEDONE).
`timescale 1ns/1ps
module tb_vram_rd_ctrl;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 64;
  localparam int BURST_LEN   = 4;
  localparam int H_PIX       = 8;
  localparam int V_PIX       = 2;
  localparam int PIX_BYTES   = 4;
  localparam int BEAT_BYTES  = DATA_W / 8;
  localparam int BURST_BYTES = BURST_LEN * BEAT_BYTES;
  localparam int NB          = (H_PIX * V_PIX * PIX_BYTES) / BURST_BYTES;
  localparam int EXP_SIZE    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              axistart;
  logic              dispon;
  logic [ADDR_W-1:0] dispaddr;
  logic              fifoready = 1'b1;

  // Environment knobs, written only by the main sequence.
  int                ar_mode;      // 0 always ready, 1 random, 2 stalled
  int                fifo_mode;    // 0 ready, 1 random, 2 full
  int                r_delay_min;
  int                r_delay_max;
  bit                err_on;
  logic [ADDR_W-1:0] exp_base;
  int                frame_id;

  wire              busy_v    [2];
  wire              fdone_v   [2];
  wire              rerr_v    [2];
  wire              arvalid_v [2];
  wire [ADDR_W-1:0] araddr_v  [2];
  wire              rready_v  [2];
  wire [31:0]       ar_cnt_w  [2];
  wire [31:0]       fd_cnt_w  [2];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ar [2];
  int exp_fd [2];

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    fifoready = (fifo_mode == 1) ? 1'($urandom_range(0, 1)) : (fifo_mode == 0);
  end

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int MO = g + 1;

    vram_rd_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    vram_rd_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
      .H_PIX(H_PIX), .V_PIX(V_PIX), .PIX_BYTES(PIX_BYTES), .MAX_OUTST(MO)
    ) dut (
      .ACLK(clk), .ARESETN(rst_n), .axi(bus.master),
      .AXISTART(axistart), .DISPON(dispon), .DISPADDR(dispaddr), .FIFOREADY(fifoready),
      .BUSY(busy_v[g]), .FRAMEDONE(fdone_v[g]), .RERR(rerr_v[g])
    );

    int unsigned       due [$];
    int unsigned       cyc = 0;
    int                beat = 0;
    int                ar_cnt = 0;
    int                fd_cnt = 0;
    int                ar_n = 0;
    int                done_n = 0;
    int                seen_id = 0;
    bit                stall_prev = 1'b0;
    bit                arvalid_prev = 1'b0;
    logic [ADDR_W-1:0] addr_prev = '0;
    logic [ADDR_W-1:0] exp_addr;

    assign arvalid_v[g] = bus.ARVALID;
    assign araddr_v[g]  = bus.ARADDR;
    assign rready_v[g]  = bus.RREADY;
    assign ar_cnt_w[g]  = ar_cnt;
    assign fd_cnt_w[g]  = fd_cnt;

    // AXI slave plus reference model; drives at negedge, handshakes complete at the next posedge.
    always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
        due.delete();
        beat         = 0;
        stall_prev   = 1'b0;
        arvalid_prev = 1'b0;
        bus.ARREADY  = 1'b0;
        bus.RVALID   = 1'b0;
        bus.RLAST    = 1'b0;
        bus.RRESP    = 2'b00;
      end else begin
        if (frame_id != seen_id) begin
          seen_id = frame_id;
          ar_n    = 0;
          done_n  = 0;
        end
        if (stall_prev) begin
          checkOutput($sformatf("lane%0d_arvalid_hold", g), 64'(bus.ARVALID), 64'd1);
          checkOutput($sformatf("lane%0d_araddr_hold", g), 64'(bus.ARADDR), 64'(addr_prev));
        end
        if (bus.ARVALID && !arvalid_prev) begin
          checkOutput($sformatf("lane%0d_ar_rise_outst", g), 64'(due.size() < MO), 64'd1);
        end

        bus.ARREADY = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;

        bus.RVALID = 1'b0;
        bus.RLAST  = 1'b0;
        bus.RRESP  = 2'b00;
        if (due.size() > 0 && cyc >= due[0] && $urandom_range(0, 3) != 0) begin
          bus.RVALID = 1'b1;
          bus.RLAST  = (beat == BURST_LEN - 1);
          bus.RRESP  = (err_on && beat == 0) ? 2'b10 : 2'b00;
          if (bus.RREADY) begin
            if (beat == BURST_LEN - 1) begin
              beat = 0;
              void'(due.pop_front());
              done_n++;
            end else begin
              beat++;
            end
          end
        end

        if (bus.ARVALID && bus.ARREADY) begin
          exp_addr = exp_base + ADDR_W'(ar_n * BURST_BYTES);
          checkOutput($sformatf("lane%0d_araddr", g), 64'(bus.ARADDR), 64'(exp_addr));
          checkOutput($sformatf("lane%0d_arlen", g), 64'(bus.ARLEN), 64'(BURST_LEN - 1));
          checkOutput($sformatf("lane%0d_arsize", g), 64'(bus.ARSIZE), 64'(EXP_SIZE));
          checkOutput($sformatf("lane%0d_arburst", g), 64'(bus.ARBURST), 64'd1);
          checkOutput($sformatf("lane%0d_outst_limit", g), 64'(due.size() < MO), 64'd1);
          checkOutput($sformatf("lane%0d_burst_in_frame", g), 64'(ar_n < NB), 64'd1);
          due.push_back(cyc + 1 + $urandom_range(r_delay_min, r_delay_max));
          ar_n++;
          ar_cnt++;
        end

        stall_prev   = bus.ARVALID && !bus.ARREADY;
        arvalid_prev = bus.ARVALID;
        addr_prev    = bus.ARADDR;

        if (fdone_v[g]) begin
          fd_cnt++;
          checkOutput($sformatf("lane%0d_done_after_all", g), 64'(done_n), 64'(NB));
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("%s_busy%0d", tag, g), 64'(busy_v[g]), 64'd0);
      checkOutput($sformatf("%s_fdone%0d", tag, g), 64'(fdone_v[g]), 64'd0);
      checkOutput($sformatf("%s_rerr%0d", tag, g), 64'(rerr_v[g]), 64'd0);
      checkOutput($sformatf("%s_arvalid%0d", tag, g), 64'(arvalid_v[g]), 64'd0);
      checkOutput($sformatf("%s_araddr%0d", tag, g), 64'(araddr_v[g]), 64'd0);
      checkOutput($sformatf("%s_rready%0d", tag, g), 64'(rready_v[g]), 64'd1);
    end
  endtask

  task automatic check_counts(input string tag);
    for (int g = 0; g < 2; g++) begin
      checkOutput($sformatf("%s_ar_count%0d", tag, g), 64'(ar_cnt_w[g]), 64'(exp_ar[g]));
      checkOutput($sformatf("%s_fd_count%0d", tag, g), 64'(fd_cnt_w[g]), 64'(exp_fd[g]));
    end
  endtask

  task automatic check_both(input string tag, input bit v0, input bit v1, input bit expected);
    checkOutput({tag, "0"}, 64'(v0), 64'(expected));
    checkOutput({tag, "1"}, 64'(v1), 64'(expected));
  endtask

  // Request a frame at the given base: AXISTART held high for four cycles.
  task automatic applyStimulus(input logic [ADDR_W-1:0] base);
    @(negedge clk);
    exp_base = base;
    dispaddr = base;
    frame_id++;
    axistart = 1'b1;
    repeat (4) @(negedge clk);
    axistart = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy_v[0] || busy_v[1]) && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle_timeout"}, 64'(n < 400), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ar(input int target);
    int n = 0;
    while ((int'(ar_cnt_w[0]) < target || int'(ar_cnt_w[1]) < target) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("first_ar_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic run_frame(input string tag, input logic [ADDR_W-1:0] base, input bit exp_rerr);
    applyStimulus(base);
    check_both({tag, "_busy"}, busy_v[0], busy_v[1], 1'b1);
    wait_idle(tag);
    for (int g = 0; g < 2; g++) begin
      exp_ar[g] += NB;
      exp_fd[g] += 1;
    end
    check_counts(tag);
    check_both({tag, "_rerr"}, rerr_v[0], rerr_v[1], exp_rerr);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0; axistart = 1'b0; dispon = 1'b1; dispaddr = '0;
    ar_mode = 0; fifo_mode = 0; r_delay_min = 0; r_delay_max = 0; err_on = 1'b0;
    exp_base = '0; frame_id = 0;
    exp_ar[0] = 0; exp_ar[1] = 0; exp_fd[0] = 0; exp_fd[1] = 0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] basic frame at 0x1000");
    run_frame("basic", 32'h1000, 1'b0);

    $display("[TB] delayed read data");
    r_delay_min = 10; r_delay_max = 10;
    run_frame("delayed", 32'h1000, 1'b0);

    $display("[TB] randomised frames");
    for (int i = 0; i < 6; i++) begin
      ar_mode = 1; fifo_mode = 1;
      r_delay_min = 0; r_delay_max = $urandom_range(0, 12);
      run_frame($sformatf("rand%0d", i), (i == 0) ? 32'hFFFF_FFE0 : ($urandom & ~32'h1F), 1'b0);
    end

    $display("[TB] AR stall with FIFO dropping");
    ar_mode = 2; fifo_mode = 0; r_delay_min = 0; r_delay_max = 3;
    applyStimulus(32'h2000);
    begin
      int n = 0;
      while (!(arvalid_v[0] && arvalid_v[1]) && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput("stall_arvalid_timeout", 64'(n < 50), 64'd1);
    end
    fifo_mode = 2;
    repeat (5) @(negedge clk);
    check_both("stall_arvalid", arvalid_v[0], arvalid_v[1], 1'b1);
    checkOutput("stall_araddr0", 64'(araddr_v[0]), 64'h2000);
    checkOutput("stall_araddr1", 64'(araddr_v[1]), 64'h2000);
    ar_mode = 0; fifo_mode = 0;
    wait_idle("stall");
    for (int g = 0; g < 2; g++) begin
      exp_ar[g] += NB;
      exp_fd[g] += 1;
    end
    check_counts("stall");

    $display("[TB] abort by DISPON");
    r_delay_min = 10; r_delay_max = 12;
    applyStimulus(32'h3000);
    wait_ar(exp_ar[0] + 1);
    dispon = 1'b0;
    @(negedge clk);
    check_both("abort_busy", busy_v[0], busy_v[1], 1'b1);
    wait_idle("abort");
    exp_ar[0] += 1; exp_ar[1] += 1;
    check_counts("abort");
    dispon = 1'b1;

    $display("[TB] error response and ignored restart");
    err_on = 1'b1; r_delay_min = 10; r_delay_max = 10;
    applyStimulus(32'h4000);
    repeat (2) @(negedge clk);
    axistart = 1'b1;
    repeat (4) @(negedge clk);
    axistart = 1'b0;
    check_both("restart_busy", busy_v[0], busy_v[1], 1'b1);
    wait_idle("rerr");
    for (int g = 0; g < 2; g++) begin
      exp_ar[g] += NB;
      exp_fd[g] += 1;
    end
    check_counts("rerr");
    check_both("rerr_set", rerr_v[0], rerr_v[1], 1'b1);
    err_on = 1'b0;
    repeat (10) @(negedge clk);
    check_both("rerr_sticky", rerr_v[0], rerr_v[1], 1'b1);
    r_delay_min = 5; r_delay_max = 5;
    applyStimulus(32'h5000);
    check_both("rerr_cleared", rerr_v[0], rerr_v[1], 1'b0);
    wait_idle("after_rerr");
    for (int g = 0; g < 2; g++) begin
      exp_ar[g] += NB;
      exp_fd[g] += 1;
    end
    check_counts("after_rerr");

    $display("[TB] reset mid-frame");
    r_delay_min = 8; r_delay_max = 8;
    applyStimulus(32'h6000);
    wait_ar(exp_ar[0] + 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    exp_ar[0] += 1; exp_ar[1] += 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_both("post_reset_busy", busy_v[0], busy_v[1], 1'b0);
    check_counts("post_reset");
    r_delay_min = 0; r_delay_max = 4;
    run_frame("post_reset_frame", 32'h7000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_rd_ctrl.md
VRAM_RD_CTRL -- requirements
Module: vram_rd_ctrl

Interface
REQ-001 Parameter ADDR_W, 32: AXI address width.
REQ-002 Parameter DATA_W, 64: R data width in bits (32/64/128).
REQ-003 Parameter BURST_LEN, 16: beats per burst (1..256, power of two).
REQ-004 Parameter H_PIX, 640 / V_PIX, 480 / PIX_BYTES, 4: frame geometry; frame bytes are an exact multiple of the burst bytes.
REQ-005 Parameter MAX_OUTST, 2: maximum outstanding read bursts (1..4).
REQ-006 ACLK in 1: sole clock, all logic on its rising edge.
REQ-007 ARESETN in 1: reset, asynchronous assert, active-low.
REQ-008 AXI AR outputs ARADDR[ADDR_W], ARLEN[8], ARSIZE[3], ARBURST[2], ARVALID; input ARREADY.
REQ-009 AXI R inputs RVALID, RLAST, RRESP[2]; output RREADY.
REQ-010 AXISTART in 1: frame-start request, asynchronous to ACLK.
REQ-011 DISPON in 1: display enable. DISPADDR in ADDR_W: frame base, burst-aligned.
REQ-012 FIFOREADY in 1: downstream pixel FIFO has room for one more burst.
REQ-013 BUSY out 1; FRAMEDONE out 1 (one-cycle pulse); RERR out 1 (sticky).

Function
REQ-014 ARLEN SHALL be BURST_LEN-1, ARSIZE log2(DATA_W/8), ARBURST 2'b01 (INCR), all constant.
REQ-015 AXISTART SHALL pass a 3-flop synchroniser; a frame starts on a 0->1 edge seen on the last two flops while DISPON=1 and state is IDLE; edges in other states are ignored.
REQ-016 At frame start, DISPADDR SHALL be latched; ARADDR = latched base + burst index * BURST_LEN*DATA_W/8, truncated to ADDR_W.
REQ-017 States: IDLE, RUN, DRAIN. IDLE->RUN on frame start; RUN->DRAIN when the last burst is accepted or DISPON=0; DRAIN->IDLE when outstanding count is 0.
REQ-018 In RUN, ARVALID SHALL rise only when bursts remain, outstanding < MAX_OUTST and FIFOREADY=1.
REQ-019 Once raised, ARVALID and ARADDR SHALL hold stable until ARREADY; FIFOREADY or DISPON falling SHALL NOT withdraw it.
REQ-020 The outstanding counter SHALL increment on AR handshake and decrement on RVALID&RREADY&RLAST; on a same-cycle AR handshake and last beat it SHALL be unchanged.
REQ-021 RREADY SHALL be 1 in every state after reset, so all outstanding data is drained.
REQ-022 FRAMEDONE SHALL pulse for one cycle on the DRAIN->IDLE transition only if every burst of the frame was issued; aborts (DISPON=0 mid-frame) SHALL NOT pulse.
REQ-023 RERR SHALL set on any beat with RRESP!=0 and clear only at the next frame start or reset.
REQ-024 BUSY SHALL be 1 whenever state is not IDLE.
REQ-025 The burst counter SHALL be sized as clog2(frame bytes / burst bytes)+1 bits; no wrap within a frame.

Reset
REQ-026 On ARESETN=0: state IDLE, ARVALID 0, counters 0, synchroniser 0, BUSY/FRAMEDONE/RERR 0, ARADDR 0; RREADY 1.
REQ-027 Reset mid-frame SHALL abandon all bursts; the first frame after release needs a new AXISTART edge.

Structure
REQ-028 State encoding, ARBURST/RRESP constants and the burst-byte/burst-count functions SHALL be in shared package vram_pkg.
REQ-029 The AXISTART synchroniser and edge detector SHALL be sub-module sync_edge (3 flops, rising-edge pulse out).

Verification
REQ-030 H=8,V=2,PIX=4,DATA_W=64,BURST_LEN=4, DISPADDR=0x1000, ARREADY=1, FIFOREADY=1 -> ARADDR 0x1000 then 0x1020, ARLEN=3, ARSIZE=3, FRAMEDONE one pulse after second RLAST.
REQ-031 Same parameters, MAX_OUTST=1, R delayed 10 cycles -> second ARVALID not before first RLAST handshake.
REQ-032 ARREADY held 0 for 5 cycles while FIFOREADY drops -> ARVALID/ARADDR stable across all 5 cycles.
REQ-033 DISPON=0 after first AR accepted -> no further AR, BUSY falls after its RLAST, FRAMEDONE stays 0.
REQ-034 RRESP=2'b10 on one beat -> RERR=1 until next frame start; AXISTART edge while BUSY -> ignored.
REQ-035 ARESETN low mid-burst -> all outputs at reset values immediately, no AR until new AXISTART edge.
